// File: rtl/order_msg_parser.sv
// Byte-stream parser for 'A' (add, 28 B) and 'U' (modify, 40 B) order messages.
// Build macro PARSER_SIDE_CHECK_EN: only 'B'/'S' side bytes are legal, anything else drops the message.
module order_msg_parser #(
    parameter int MAX_LEN = 40
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_sof,
    output logic        in_ready,
    output logic        msg_valid,
    output logic        msg_type,
    output logic [47:0] symbol_id,
    output logic        side,
    output logic [63:0] price,
    output logic [63:0] orig_price,
    output logic [63:0] quantity,
    output logic [31:0] order_id,
    output logic [31:0] orig_order_id,
    output logic [15:0] err_cnt
);
    localparam int CNT_W = (MAX_LEN > 2) ? $clog2(MAX_LEN) : 1;
    localparam logic [CNT_W-1:0] ADD_LAST = CNT_W'(27);
    localparam logic [CNT_W-1:0] MOD_LAST = CNT_W'(39);

    typedef enum logic [1:0] {IDLE, BODY, EMIT, DROP} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             is_mod_q, is_mod_d;
    logic             side_h_q, side_h_d;
    logic [47:0]      sym_h_q, sym_h_d;
    logic [31:0]      oid_h_q, oid_h_d, ooid_h_q, ooid_h_d;
    logic [63:0]      price_h_q, price_h_d, oprice_h_q, oprice_h_d, qty_h_q, qty_h_d;
    logic             msg_type_q, msg_type_d, side_q, side_d;
    logic [47:0]      symbol_q, symbol_d;
    logic [31:0]      oid_q, oid_d, ooid_q, ooid_d;
    logic [63:0]      price_q, price_d, oprice_q, oprice_d, qty_q, qty_d;
    logic [15:0]      err_q, err_d;
    logic             msg_valid_q, msg_valid_d, in_ready_q, in_ready_d;
    logic             accept, side_err;
    logic [1:0]       err_inc;
    logic [16:0]      err_sum;
    logic [CNT_W-1:0] last_off;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_mod_d    = is_mod_q;
        side_h_d    = side_h_q;
        sym_h_d     = sym_h_q;
        oid_h_d     = oid_h_q;
        ooid_h_d    = ooid_h_q;
        price_h_d   = price_h_q;
        oprice_h_d  = oprice_h_q;
        qty_h_d     = qty_h_q;
        msg_type_d  = msg_type_q;
        side_d      = side_q;
        symbol_d    = symbol_q;
        oid_d       = oid_q;
        ooid_d      = ooid_q;
        price_d     = price_q;
        oprice_d    = oprice_q;
        qty_d       = qty_q;
        err_inc     = 2'd0;
        side_err    = 1'b0;
        accept      = in_valid && in_ready_q;
        last_off    = is_mod_q ? MOD_LAST : ADD_LAST;

        // Body byte: cnt_q is the byte offset within the message.
        if (accept && state_q == BODY && !in_sof) begin
            if (cnt_q == CNT_W'(1)) begin
`ifdef PARSER_SIDE_CHECK_EN
                side_h_d = (in_data == 8'h42);
                side_err = (in_data != 8'h42) && (in_data != 8'h53);
`else
                side_h_d = (in_data == 8'h42);
`endif
            end else if (cnt_q <= CNT_W'(7)) begin
                sym_h_d = {sym_h_q[39:0], in_data};
            end else if (cnt_q <= CNT_W'(11)) begin
                oid_h_d = {oid_h_q[23:0], in_data};
            end else if (!is_mod_q) begin
                if (cnt_q <= CNT_W'(19)) price_h_d = {price_h_q[55:0], in_data};
                else                     qty_h_d   = {qty_h_q[55:0], in_data};
            end else begin
                if (cnt_q <= CNT_W'(15))      ooid_h_d   = {ooid_h_q[23:0], in_data};
                else if (cnt_q <= CNT_W'(23)) price_h_d  = {price_h_q[55:0], in_data};
                else if (cnt_q <= CNT_W'(31)) oprice_h_d = {oprice_h_q[55:0], in_data};
                else                          qty_h_d    = {qty_h_q[55:0], in_data};
            end

            if (side_err) begin
                state_d = DROP;
                err_inc = 2'd1;
            end else if (cnt_q == last_off) begin
                // Outputs take the shifted values so the last byte lands in EMIT.
                state_d    = EMIT;
                msg_type_d = is_mod_q;
                side_d     = side_h_d;
                symbol_d   = sym_h_d;
                oid_d      = oid_h_d;
                ooid_d     = is_mod_q ? ooid_h_d : 32'd0;
                price_d    = price_h_d;
                oprice_d   = is_mod_q ? oprice_h_d : 64'd0;
                qty_d      = qty_h_d;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        if (state_q == EMIT) state_d = IDLE;

        // A start-of-frame byte is a type byte in any accepting state; in BODY it also aborts.
        if (accept && in_sof && state_q != EMIT) begin
            if (state_q == BODY) err_inc = err_inc + 2'd1;
            if (in_data == 8'h41 || in_data == 8'h55) begin
                state_d  = BODY;
                is_mod_d = (in_data == 8'h55);
                cnt_d    = CNT_W'(1);
            end else begin
                state_d = DROP;
                err_inc = err_inc + 2'd1;
            end
        end

        err_sum     = {1'b0, err_q} + {15'd0, err_inc};
        err_d       = err_sum[16] ? 16'hFFFF : err_sum[15:0];
        msg_valid_d = (state_d == EMIT);
        in_ready_d  = (state_d != EMIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            is_mod_q    <= 1'b0;
            side_h_q    <= 1'b0;
            sym_h_q     <= '0;
            oid_h_q     <= '0;
            ooid_h_q    <= '0;
            price_h_q   <= '0;
            oprice_h_q  <= '0;
            qty_h_q     <= '0;
            msg_type_q  <= 1'b0;
            side_q      <= 1'b0;
            symbol_q    <= '0;
            oid_q       <= '0;
            ooid_q      <= '0;
            price_q     <= '0;
            oprice_q    <= '0;
            qty_q       <= '0;
            err_q       <= '0;
            msg_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_mod_q    <= is_mod_d;
            side_h_q    <= side_h_d;
            sym_h_q     <= sym_h_d;
            oid_h_q     <= oid_h_d;
            ooid_h_q    <= ooid_h_d;
            price_h_q   <= price_h_d;
            oprice_h_q  <= oprice_h_d;
            qty_h_q     <= qty_h_d;
            msg_type_q  <= msg_type_d;
            side_q      <= side_d;
            symbol_q    <= symbol_d;
            oid_q       <= oid_d;
            ooid_q      <= ooid_d;
            price_q     <= price_d;
            oprice_q    <= oprice_d;
            qty_q       <= qty_d;
            err_q       <= err_d;
            msg_valid_q <= msg_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign msg_valid     = msg_valid_q;
    assign msg_type      = msg_type_q;
    assign symbol_id     = symbol_q;
    assign side          = side_q;
    assign price         = price_q;
    assign orig_price    = oprice_q;
    assign quantity      = qty_q;
    assign order_id      = oid_q;
    assign orig_order_id = ooid_q;
    assign err_cnt       = err_q;
endmodule

// File: tb/tb_order_msg_parser.sv
// Directed bench for order_msg_parser: messages are built from field values, a layout-level
// decoder predicts each emitted message, and one negedge process compares every cycle.
module tb_order_msg_parser;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_sof = 1'b0;
    logic        in_ready, msg_valid, msg_type, side;
    logic [47:0] symbol_id;
    logic [63:0] price, orig_price, quantity;
    logic [31:0] order_id, orig_order_id;
    logic [15:0] err_cnt;

    order_msg_parser #(.MAX_LEN(40)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof),
        .in_ready(in_ready), .msg_valid(msg_valid), .msg_type(msg_type), .symbol_id(symbol_id),
        .side(side), .price(price), .orig_price(orig_price), .quantity(quantity),
        .order_id(order_id), .orig_order_id(orig_order_id), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        t;
        logic        s;
        logic [47:0] sym;
        logic [31:0] oid, ooid;
        logic [63:0] pr, opr, qty;
        int          cyc;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       last;
    logic [7:0] mb[$];
    int         pulse_cyc[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         exp_err = 0;
    bit         armed = 1'b0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // ---- model: decode a byte list by the message layout ----
    function automatic logic [63:0] get_be(input int start, input int n);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v = {v[55:0], mb[start+i]};
        return v;
    endfunction

    function automatic exp_t model_decode();
        exp_t e;
        e     = '{default: 0};
        e.t   = (mb[0] == 8'h55);
        e.s   = (mb[1] == 8'h42);
        e.sym = 48'(get_be(2, 6));
        e.oid = 32'(get_be(8, 4));
        if (e.t) begin
            e.ooid = 32'(get_be(12, 4));
            e.pr   = get_be(16, 8);
            e.opr  = get_be(24, 8);
            e.qty  = get_be(32, 8);
        end else begin
            e.pr  = get_be(12, 8);
            e.qty = get_be(20, 8);
        end
        return e;
    endfunction

    // ---- message builders ----
    task automatic put_be(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) mb.push_back(v[8*i +: 8]);
    endtask

    task automatic build_add(input logic [7:0] s, input logic [47:0] sym, input logic [31:0] oid,
                             input logic [63:0] pr, input logic [63:0] qty);
        mb.delete();
        mb.push_back(8'h41);
        mb.push_back(s);
        put_be(sym, 6); put_be(64'(oid), 4); put_be(pr, 8); put_be(qty, 8);
    endtask

    task automatic build_mod(input logic [7:0] s, input logic [47:0] sym, input logic [31:0] oid,
                             input logic [31:0] ooid, input logic [63:0] pr, input logic [63:0] opr,
                             input logic [63:0] qty);
        mb.delete();
        mb.push_back(8'h55);
        mb.push_back(s);
        put_be(sym, 6); put_be(64'(oid), 4); put_be(64'(ooid), 4);
        put_be(pr, 8); put_be(opr, 8); put_be(qty, 8);
    endtask

    // ---- drivers ----
    task automatic send_byte(input logic [7:0] b, input logic sof);
        int waited;
        waited = 0;
        @(negedge clk);
        in_data  = b;
        in_sof   = sof;
        in_valid = 1'b1;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: in_ready low for %0d cycles, expected high", waited);
        end
    endtask

    task automatic send_part(input int n);
        for (int i = 0; i < n; i++) send_byte(mb[i], (i == 0));
    endtask

    task automatic send_msg(input bit ok);
        exp_t e;
        send_part(mb.size());
        if (ok) begin
            e     = model_decode();
            e.cyc = cyc + 1;
            exp_q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    // ---- cycle counter and per-cycle compare ----
    always @(posedge clk) begin
        cyc++;
        armed = rst_n;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_msg_valid", 64'(msg_valid), 64'd0);
            chk("rst_in_ready", 64'(in_ready), 64'd0);
            chk("rst_err_cnt", 64'(err_cnt), 64'd0);
            chk("rst_fields", 64'((|price) | (|orig_price) | (|quantity) | (|symbol_id) |
                                  (|order_id) | (|orig_order_id) | side | msg_type), 64'd0);
            last = '{default: 0};
        end else begin
            if (armed) chk("in_ready_low_only_in_emit", 64'(in_ready), 64'(!msg_valid));
            if (msg_valid) begin
                pulse_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_msg_valid: pulse at cycle %0d, expected none", cyc);
                end else begin
                    last = exp_q.pop_front();
                    chk("pulse_cycle", 64'(cyc), 64'(last.cyc));
                end
            end
            chk("msg_type", 64'(msg_type), 64'(last.t));
            chk("side", 64'(side), 64'(last.s));
            chk("symbol_id", 64'(symbol_id), 64'(last.sym));
            chk("order_id", 64'(order_id), 64'(last.oid));
            chk("orig_order_id", 64'(orig_order_id), 64'(last.ooid));
            chk("price", price, last.pr);
            chk("orig_price", orig_price, last.opr);
            chk("quantity", quantity, last.qty);
        end
    end

    // ---- directed sequence ----
    initial begin
        exp_t e;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("ready_before_first_edge", 64'(in_ready), 64'd0);
        @(negedge clk);
        chk("ready_after_first_edge", 64'(in_ready), 64'd1);

        // non-SOF byte in IDLE is ignored
        send_byte(8'h41, 1'b0);
        idle(3);
        chk("stray_byte_err", 64'(err_cnt), 64'd0);

        // add message
        build_add(8'h42, 48'h000000414243, 32'd7, 64'd100, 64'd50);
        e = model_decode();
        chk("model_add_len", 64'(mb.size()), 64'd28);
        chk("model_add_price", e.pr, 64'd100);
        chk("model_add_qty", e.qty, 64'd50);
        chk("model_add_sym", 64'(e.sym), 64'h000000414243);
        send_msg(1'b1);
        idle(3);
        chk("add_type_lit", 64'(msg_type), 64'd0);
        chk("add_side_lit", 64'(side), 64'd1);
        chk("add_symbol_lit", 64'(symbol_id), 64'h000000414243);
        chk("add_order_id_lit", 64'(order_id), 64'd7);
        chk("add_price_lit", price, 64'd100);
        chk("add_qty_lit", quantity, 64'd50);
        chk("add_orig_price_lit", orig_price, 64'd0);
        chk("add_orig_oid_lit", 64'(orig_order_id), 64'd0);

        // modify message
        build_mod(8'h53, 48'h00004D534654, 32'd9, 32'd7, 64'd101, 64'd100, 64'd20);
        e = model_decode();
        chk("model_mod_len", 64'(mb.size()), 64'd40);
        chk("model_mod_ooid", 64'(e.ooid), 64'd7);
        chk("model_mod_opr", e.opr, 64'd100);
        send_msg(1'b1);
        idle(3);
        chk("mod_type_lit", 64'(msg_type), 64'd1);
        chk("mod_side_lit", 64'(side), 64'd0);
        chk("mod_symbol_lit", 64'(symbol_id), 64'h00004D534654);
        chk("mod_order_id_lit", 64'(order_id), 64'd9);
        chk("mod_orig_oid_lit", 64'(orig_order_id), 64'd7);
        chk("mod_price_lit", price, 64'd101);
        chk("mod_orig_price_lit", orig_price, 64'd100);
        chk("mod_qty_lit", quantity, 64'd20);

        // bad type byte, 27 trailing bytes, then a good add
        mb.delete();
        mb.push_back(8'h58);
        for (int i = 0; i < 27; i++) mb.push_back(8'(i + 1));
        send_part(28);
        exp_err++;
        build_add(8'h42, 48'h000000414141, 32'd11, 64'd200, 64'd3);
        send_msg(1'b1);
        idle(3);
        chk("badtype_err", 64'(err_cnt), 64'(exp_err));
        chk("badtype_err_lit", 64'(err_cnt), 64'd1);

        // SOF at byte 10 aborts an add; the new add is emitted
        build_add(8'h53, 48'h000000585858, 32'd21, 64'd555, 64'd66);
        send_part(10);
        exp_err++;
        build_add(8'h42, 48'h0000004A4B4C, 32'd22, 64'd777, 64'd88);
        send_msg(1'b1);
        idle(3);
        chk("abort_err", 64'(err_cnt), 64'(exp_err));
        chk("abort_price_lit", price, 64'd777);

        // back-to-back adds with in_valid held high
        pulse_cyc.delete();
        build_add(8'h42, 48'h000000313131, 32'd31, 64'd1000, 64'd10);
        send_msg(1'b1);
        build_add(8'h53, 48'h000000323232, 32'd32, 64'd2000, 64'd20);
        send_msg(1'b1);
        idle(4);
        chk("b2b_pulse_count", 64'(pulse_cyc.size()), 64'd2);
        if (pulse_cyc.size() == 2)
            chk("b2b_pulse_spacing", 64'(pulse_cyc[1] - pulse_cyc[0]), 64'd29);

        // reset in the middle of a message
        build_add(8'h42, 48'h000000343434, 32'd41, 64'd300, 64'd30);
        send_part(15);
        @(negedge clk);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        exp_err = 0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_release_ready_low", 64'(in_ready), 64'd0);
        @(negedge clk);
        chk("rst_release_ready_high", 64'(in_ready), 64'd1);
        build_add(8'h42, 48'h000000515253, 32'd42, 64'd400, 64'd40);
        send_msg(1'b1);
        idle(3);
        chk("rst_err_zero", 64'(err_cnt), 64'd0);
        chk("rst_new_price_lit", price, 64'd400);

        // side byte 0x51
`ifdef PARSER_SIDE_CHECK_EN
        build_add(8'h51, 48'h000000616263, 32'd51, 64'd500, 64'd5);
        send_msg(1'b0);
        exp_err++;
        idle(3);
        chk("side_err_cnt", 64'(err_cnt), 64'(exp_err));
        chk("side_err_cnt_lit", 64'(err_cnt), 64'd1);
        chk("side_err_price_held", price, 64'd400);
`else
        build_add(8'h51, 48'h000000616263, 32'd51, 64'd500, 64'd5);
        send_msg(1'b1);
        idle(3);
        chk("side_other_lit", 64'(side), 64'd0);
        chk("side_other_err", 64'(err_cnt), 64'd0);
        chk("side_other_price_lit", price, 64'd500);
`endif

        idle(5);
        chk("no_missing_msg_valid", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
